// File: rtl/mcu_playlist.sv
// Playlist playback controller: play/pause, next, prev (restart or step back),
// end-of-song modes, and a one-cycle player-reset pulse on every song change.
module mcu_playlist #(
  parameter int NUM_SONGS     = 4,
  parameter int SONG_W        = 2,
  parameter int RESTART_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic [1:0]        mode,
  input  logic              beat,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  localparam int BW = $clog2(RESTART_BEATS + 1);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [BW-1:0]     BEAT_MAX  = BW'(RESTART_BEATS);

  typedef enum logic [1:0] {PAUSED, PLAYING, SWITCH} state_t;

  state_t            state, state_nx;
  logic [SONG_W-1:0] song_nx, song_inc, song_dec;
  logic              resume, resume_nx;
  logic [BW-1:0]     beat_cnt, beat_cnt_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PAUSED;
      song     <= '0;
      resume   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      song     <= song_nx;
      resume   <= resume_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    song_inc = (song == LAST_SONG) ? '0 : song + 1'b1;
    song_dec = (song == '0) ? LAST_SONG : song - 1'b1;
  end

  always_comb begin
    state_nx    = state;
    song_nx     = song;
    resume_nx   = resume;
    beat_cnt_nx = beat_cnt;
    case (state)
      SWITCH: state_nx = resume ? PLAYING : PAUSED;
      default: begin
        if (state == PLAYING && beat && beat_cnt != BEAT_MAX)
          beat_cnt_nx = beat_cnt + BW'(1);
        // Priority chain: only the first matching event acts.
        if (next_button) begin
          song_nx   = song_inc;
          resume_nx = (state == PLAYING);
          state_nx  = SWITCH;
        end else if (prev_button) begin
          song_nx   = (beat_cnt >= BEAT_MAX) ? song : song_dec;
          resume_nx = (state == PLAYING);
          state_nx  = SWITCH;
        end else if (song_done && state == PLAYING) begin
          resume_nx = 1'b1;
          state_nx  = SWITCH;
          case (mode)
            2'b10: song_nx = song;
            2'b00: begin
              song_nx = song_inc;
              if (song == LAST_SONG) resume_nx = 1'b0;
            end
            default: song_nx = song_inc;
          endcase
        end else if (play_button) begin
          state_nx = (state == PLAYING) ? PAUSED : PLAYING;
        end
        if (state_nx == SWITCH) beat_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    play         = (state == PLAYING);
    reset_player = (state == SWITCH);
  end

endmodule

// File: tb/tb_mcu_playlist.sv
// Bench for mcu_playlist: directed scenarios with literal expectations, then
// random stimulus, all checked each cycle against a behavioural model.
module tb_mcu_playlist;
  localparam int N  = 4;
  localparam int RB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       beat = 1'b0, song_done = 1'b0;
  logic       play, reset_player;
  logic [1:0] song;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: playback flag, whether a song change is in progress, etc.
  bit m_playing = 0, m_sw = 0, m_resume = 0;
  int m_song = 0, m_beats = 0;

  mcu_playlist #(.NUM_SONGS(N), .SONG_W(2), .RESTART_BEATS(RB)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode(mode), .beat(beat), .song_done(song_done),
    .play(play), .reset_player(reset_player), .song(song)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_playing = 0; m_sw = 0; m_resume = 0; m_song = 0; m_beats = 0;
    end else if (m_sw) begin
      m_sw = 0;
      m_playing = m_resume;
    end else begin
      bit change;
      int target;
      bit res;
      change = 0; target = m_song; res = m_playing;
      if (next_button) begin
        change = 1; target = (m_song + 1) % N;
      end else if (prev_button) begin
        change = 1; target = (m_beats >= RB) ? m_song : (m_song + N - 1) % N;
      end else if (song_done && m_playing) begin
        change = 1; res = 1;
        if (mode == 2'b10) target = m_song;
        else target = (m_song + 1) % N;
        if (mode == 2'b00 && m_song == N - 1) res = 0;
      end
      if (change) begin
        m_sw = 1; m_song = target; m_resume = res; m_beats = 0;
      end else begin
        if (beat && m_playing && m_beats < RB) m_beats++;
        if (play_button) m_playing = !m_playing;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("play", int'(play), int'(m_playing && !m_sw));
      chk("reset_player", int'(reset_player), int'(m_sw));
      chk("song", int'(song), m_song);
    end
  end

  task automatic cyc(input bit p, input bit n, input bit pv, input bit sd, input bit bt);
    @(negedge clk);
    #1;
    play_button = p; next_button = n; prev_button = pv; song_done = sd; beat = bt;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Outputs as seen one cycle after the previous cyc() call took effect.
  task automatic lit(input string name, input int p, input int rp, input int s);
    chk({name, "_play"}, int'(play), p);
    chk({name, "_rp"}, int'(reset_player), rp);
    chk({name, "_song"}, int'(song), s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);

    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("play_on", 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      lit("next_sw", 0, 1, i);
      cyc(0, 0, 0, 0, 0);
      lit("next_after", 1, 0, i);
      idle(2);
    end

    mode = 2'b00;
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    lit("stop_end_sw", 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    lit("stop_end_after", 0, 0, 0);
    cyc(0, 0, 1, 0, 0); idle(2);
    lit("prev_wrap_paused", 0, 0, 3);
    cyc(1, 0, 0, 0, 0); idle(1);
    mode = 2'b01;
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    lit("loop_all_sw", 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    lit("loop_all_after", 1, 0, 0);
    cyc(0, 0, 1, 0, 0); idle(2);
    mode = 2'b10;
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    lit("repeat_sw", 0, 1, 3);
    cyc(0, 0, 0, 0, 0);
    lit("repeat_after", 1, 0, 3);

    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0, 0, 0); idle(2); end
    lit("at_song2", 1, 0, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("prev_step", 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("prev_restart", 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); idle(2);
    lit("prev_after_restart", 1, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("prev_wrap", 0, 1, 3);
    idle(1);

    cyc(0, 1, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0, 0); idle(2);
    lit("at_song1", 1, 0, 1);
    cyc(1, 1, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    lit("same_cycle_sw", 0, 1, 2);
    cyc(0, 0, 0, 0, 0);
    lit("same_cycle_after", 1, 0, 2);

    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("next_in_switch", 1, 0, 3);
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0); idle(2);
    lit("done_paused", 0, 0, 3);

    cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
    lit("pre_async_sw", 0, 1, 2);
    #1 reset = 1'b0;
    #1 lit("async_reset", 0, 0, 0);
    @(negedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b0;
        #1 lit("rand_async_reset", 0, 0, 0);
        @(negedge clk); #1 reset = 1'b1;
      end
    end
    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
